uart_pwm_cmd: RTL and testbench



---
 rtl/uart_pwm_cmd_pkg.sv | 23 ++
 rtl/uart_pwm_cmd_byte_timer.sv | 30 +++
 rtl/uart_pwm_cmd.sv | 147 ++++++++++++++
 tb/tb_uart_pwm_cmd.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pwm_cmd_pkg.sv
// Shared constants, FSM state encoding and frame checksum for the UART PWM
// command decoder.
package uart_pwm_cmd_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam logic [7:0] ACK_BYTE  = 8'h5A;
  localparam logic [7:0] NAK_BYTE  = 8'hEE;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CH   = 3'd1,
    ST_HI   = 3'd2,
    ST_LO   = 3'd3,
    ST_CHK  = 3'd4
  } state_t;

  function automatic logic [7:0] frame_chk(input logic [7:0] ch,
                                           input logic [7:0] hi,
                                           input logic [7:0] lo);
    return ch ^ hi ^ lo;
  endfunction

endpackage

// File: rtl/uart_pwm_cmd_byte_timer.sv
// Inter-byte gap timer: reloads on every received byte, holds expire high
// once the full gap has elapsed without a reload.
module byte_timer #(
  parameter int unsigned CYCLES = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic reload,
  output logic expire
);

  localparam int unsigned     CW   = (CYCLES > 32'd1) ? $clog2(CYCLES) : 1;
  localparam logic [CW-1:0]   LOAD = CW'(CYCLES - 32'd1);

  logic [CW-1:0] cnt;

  // Down-counter that parks at zero until the next reload.
  always_ff @(posedge clk) begin
    if (rst || reload) begin
      cnt <= LOAD;
    end else if (cnt != '0) begin
      cnt <= cnt - CW'(1);
    end else begin
      cnt <= cnt;
    end
  end

  assign expire = (cnt == '0);

endmodule

// File: rtl/uart_pwm_cmd.sv
// UART command decoder: parses A5/ch/hi/lo/chk frames into clamped PWM duty
// words, counts rejected frames and queues a single-entry ACK/NAK response.
module uart_pwm_cmd
  import uart_pwm_cmd_pkg::*;
#(
  parameter int unsigned       clk_freq   = 50000000,
  parameter int unsigned       NUM_CH     = 4,
  parameter int unsigned       DUTY_W     = 16,
  parameter logic [DUTY_W-1:0] DUTY_MAX   = 16'd50000,
  parameter int unsigned       TIMEOUT_US = 1000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [7:0]               rx_data,
  input  logic                     rx_avail,
  input  logic                     tx_busy,
  output logic [7:0]               tx_data,
  output logic                     tx_wr,
  output logic [NUM_CH*DUTY_W-1:0] duty,
  output logic [NUM_CH-1:0]        duty_upd,
  output logic [7:0]               err_cnt
);

  // 64-bit arithmetic: TIMEOUT_US * clk_freq overflows 32 bits at typical rates.
  localparam longint unsigned TO_RAW = (64'(TIMEOUT_US) * 64'(clk_freq)) / 64'd1000000;
  localparam int unsigned     TO_CYC = (TO_RAW == 64'd0) ? 32'd1 : 32'(TO_RAW);

  state_t            state, state_nx;
  logic [7:0]        ch_b, hi_b, lo_b;
  logic              expire, accept, reject, tmo, chk_ok, ch_ok;
  logic [DUTY_W-1:0] raw, clamped;
  logic              pend;
  logic [7:0]        pend_byte, sent_byte;

  byte_timer #(.CYCLES(TO_CYC)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .reload (rx_avail),
    .expire (expire)
  );

  // Frame FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  // Next state and frame verdict; a byte in the same cycle as expiry wins.
  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    reject   = 1'b0;
    tmo      = 1'b0;
    chk_ok   = (rx_data == frame_chk(ch_b, hi_b, lo_b));
    ch_ok    = (32'(ch_b) < NUM_CH);
    if (rx_avail) begin
      case (state)
        ST_IDLE: begin
          if (rx_data == SYNC_BYTE) state_nx = ST_CH;
          else                      state_nx = ST_IDLE;
        end
        ST_CH:   state_nx = ST_HI;
        ST_HI:   state_nx = ST_LO;
        ST_LO:   state_nx = ST_CHK;
        ST_CHK: begin
          state_nx = ST_IDLE;
          accept   = chk_ok && ch_ok;
          reject   = !(chk_ok && ch_ok);
        end
        default: state_nx = ST_IDLE;
      endcase
    end else if (expire && (state != ST_IDLE)) begin
      state_nx = ST_IDLE;
      tmo      = 1'b1;
    end else begin
      state_nx = state;
    end
  end

  // Capture frame fields as they arrive.
  always_ff @(posedge clk) begin
    if (rst) begin
      ch_b <= 8'd0;
      hi_b <= 8'd0;
      lo_b <= 8'd0;
    end else if (rx_avail) begin
      case (state)
        ST_CH:   ch_b <= rx_data;
        ST_HI:   hi_b <= rx_data;
        ST_LO:   lo_b <= rx_data;
        default: ;
      endcase
    end
  end

  // Truncate to the duty width, then saturate at the ceiling.
  always_comb begin
    raw = DUTY_W'({hi_b, lo_b});
    if (raw > DUTY_MAX) clamped = DUTY_MAX;
    else                clamped = raw;
  end

  // Duty words and their one-cycle update strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      duty     <= '0;
      duty_upd <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        duty_upd[i] <= accept && (ch_b == 8'(i));
        if (accept && (ch_b == 8'(i))) duty[i*DUTY_W +: DUTY_W] <= clamped;
      end
    end
  end

  // Saturating reject counter (bad frames and timeouts).
  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt <= 8'd0;
    end else if ((reject || tmo) && (err_cnt != 8'hFF)) begin
      err_cnt <= err_cnt + 8'd1;
    end
  end

  // Strobe is qualified by the live tx_busy so it never fires into a busy transmitter.
  assign tx_wr   = pend && !tx_busy && !rst;
  assign tx_data = tx_wr ? pend_byte : sent_byte;

  // Single-entry response slot; a newer verdict overwrites an unsent one.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend      <= 1'b0;
      pend_byte <= 8'd0;
      sent_byte <= 8'd0;
    end else begin
      if (tx_wr) begin
        pend      <= 1'b0;
        sent_byte <= pend_byte;
      end
      if (accept || reject) begin
        pend      <= 1'b1;
        pend_byte <= accept ? ACK_BYTE : NAK_BYTE;
      end
    end
  end

endmodule

// File: tb/tb_uart_pwm_cmd.sv
// Directed bench for uart_pwm_cmd: 1 MHz clock so the 1000 us timeout is
// 1000 cycles; expected values are hand-computed per scenario.
module tb_uart_pwm_cmd;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_avail;
  logic        tx_busy;
  logic [7:0]  tx_data;
  logic        tx_wr;
  logic [63:0] duty;
  logic [3:0]  duty_upd;
  logic [7:0]  err_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  int         tx_count   = 0;
  int         upd_cycles = 0;
  int         busy_wr    = 0;
  logic [7:0] last_tx    = 8'h00;
  logic [3:0] last_upd   = 4'h0;
  logic [63:0] exp_duty  = 64'd0;
  int t0, u0;

  always #5 clk = ~clk;

  uart_pwm_cmd #(
    .clk_freq   (1000000),
    .NUM_CH     (4),
    .DUTY_W     (16),
    .DUTY_MAX   (16'd50000),
    .TIMEOUT_US (1000)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rx_data  (rx_data),
    .rx_avail (rx_avail),
    .tx_busy  (tx_busy),
    .tx_data  (tx_data),
    .tx_wr    (tx_wr),
    .duty     (duty),
    .duty_upd (duty_upd),
    .err_cnt  (err_cnt)
  );

  always @(negedge clk) begin
    if (tx_wr === 1'b1) begin
      tx_count++;
      last_tx = tx_data;
      if (tx_busy) busy_wr++;
    end
    if (duty_upd !== 4'd0) begin
      upd_cycles++;
      last_upd = duty_upd;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_avail = 1'b1;
    @(posedge clk);
    #1;
    rx_avail = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] c, input logic [7:0] h,
                            input logic [7:0] l, input logic [7:0] k);
    send_byte(8'hA5);
    send_byte(c);
    send_byte(h);
    send_byte(l);
    send_byte(k);
  endtask

  task automatic test_reset;
    rst = 1'b1; rx_avail = 1'b0; rx_data = 8'h00; tx_busy = 1'b0;
    tick(3);
    n_checks++; if (duty !== 64'd0) begin n_fail++; $display("FAIL reset_duty: got %h expected 0", duty); end
    n_checks++; if (duty_upd !== 4'd0) begin n_fail++; $display("FAIL reset_upd: got %b expected 0", duty_upd); end
    n_checks++; if (err_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_err: got %0d expected 0", err_cnt); end
    n_checks++; if (tx_wr !== 1'b0 || tx_data !== 8'h00) begin n_fail++; $display("FAIL reset_tx: got wr=%b data=%h expected 0/00", tx_wr, tx_data); end
    rst = 1'b0;
    tick(2);
  endtask

  task automatic test_ack_ch1;
    t0 = tx_count; u0 = upd_cycles;
    send_frame(8'h01, 8'h12, 8'h34, 8'h27);
    tick(3);
    exp_duty[31:16] = 16'h1234;
    n_checks++; if (duty !== exp_duty) begin n_fail++; $display("FAIL ack_duty: got %h expected %h", duty, exp_duty); end
    n_checks++; if (upd_cycles - u0 != 1 || last_upd !== 4'b0010) begin n_fail++; $display("FAIL ack_upd: got %0d cycles of %b expected 1 of 0010", upd_cycles - u0, last_upd); end
    n_checks++; if (tx_count - t0 != 1 || last_tx !== 8'h5A) begin n_fail++; $display("FAIL ack_tx: got %0d x %h expected 1 x 5a", tx_count - t0, last_tx); end
    n_checks++; if (err_cnt !== 8'd0) begin n_fail++; $display("FAIL ack_err: got %0d expected 0", err_cnt); end
  endtask

  task automatic test_clamp;
    t0 = tx_count;
    send_frame(8'h02, 8'hFF, 8'hFF, 8'h02);
    tick(3);
    exp_duty[47:32] = 16'd50000;
    n_checks++; if (duty !== exp_duty) begin n_fail++; $display("FAIL clamp_duty: got %h expected %h", duty, exp_duty); end
    n_checks++; if (tx_count - t0 != 1 || last_tx !== 8'h5A || last_upd !== 4'b0100) begin n_fail++; $display("FAIL clamp_ack: got %0d x %h upd %b expected 1 x 5a upd 0100", tx_count - t0, last_tx, last_upd); end
  endtask

  task automatic test_reject;
    t0 = tx_count; u0 = upd_cycles;
    send_frame(8'h00, 8'h00, 8'h10, 8'h11);
    tick(3);
    send_frame(8'h07, 8'h00, 8'h10, 8'h17);
    tick(3);
    n_checks++; if (duty !== exp_duty || upd_cycles != u0) begin n_fail++; $display("FAIL reject_duty: got %h (%0d upd) expected %h (0 upd)", duty, upd_cycles - u0, exp_duty); end
    n_checks++; if (err_cnt !== 8'd2) begin n_fail++; $display("FAIL reject_err: got %0d expected 2", err_cnt); end
    n_checks++; if (tx_count - t0 != 2 || last_tx !== 8'hEE) begin n_fail++; $display("FAIL reject_tx: got %0d x %h expected 2 x ee", tx_count - t0, last_tx); end
  endtask

  task automatic test_sync_as_data;
    send_byte(8'h11);
    send_byte(8'h5A);
    tick(2);
    n_checks++; if (err_cnt !== 8'd2) begin n_fail++; $display("FAIL idle_noise_err: got %0d expected 2", err_cnt); end
    send_frame(8'h03, 8'hA5, 8'h00, 8'hA6);
    tick(3);
    exp_duty[63:48] = 16'hA500;
    n_checks++; if (duty !== exp_duty || last_tx !== 8'h5A) begin n_fail++; $display("FAIL sync_data: got %h/%h expected %h/5a", duty, last_tx, exp_duty); end
  endtask

  task automatic test_timeout;
    t0 = tx_count;
    send_byte(8'hA5);
    send_byte(8'h01);
    tick(1100);
    n_checks++; if (err_cnt !== 8'd3) begin n_fail++; $display("FAIL timeout_err: got %0d expected 3", err_cnt); end
    n_checks++; if (tx_count != t0) begin n_fail++; $display("FAIL timeout_tx: got %0d writes expected 0", tx_count - t0); end
    send_frame(8'h00, 8'h00, 8'h05, 8'h05);
    tick(3);
    exp_duty[15:0] = 16'h0005;
    n_checks++; if (duty !== exp_duty || last_tx !== 8'h5A || err_cnt !== 8'd3) begin n_fail++; $display("FAIL timeout_recover: got %h/%h/%0d expected %h/5a/3", duty, last_tx, err_cnt, exp_duty); end
  endtask

  task automatic test_gap_boundary;
    send_byte(8'hA5);
    send_byte(8'h01);
    tick(999);
    send_byte(8'h00);
    send_byte(8'h05);
    send_byte(8'h04);
    tick(3);
    exp_duty[31:16] = 16'h0005;
    n_checks++; if (duty !== exp_duty || err_cnt !== 8'd3 || last_tx !== 8'h5A) begin n_fail++; $display("FAIL gap_boundary: got %h/%0d/%h expected %h/3/5a", duty, err_cnt, last_tx, exp_duty); end
  endtask

  task automatic test_back_to_back;
    tx_busy = 1'b1;
    t0 = tx_count;
    send_frame(8'h00, 8'h01, 8'h00, 8'h01);
    send_frame(8'h01, 8'h00, 8'h02, 8'h03);
    tick(5);
    exp_duty[15:0]  = 16'h0100;
    exp_duty[31:16] = 16'h0002;
    n_checks++; if (tx_count != t0 || duty !== exp_duty) begin n_fail++; $display("FAIL busy_hold: got %0d writes duty %h expected 0 writes duty %h", tx_count - t0, duty, exp_duty); end
    tx_busy = 1'b0;
    tick(4);
    n_checks++; if (tx_count - t0 != 1 || last_tx !== 8'h5A) begin n_fail++; $display("FAIL busy_release: got %0d x %h expected 1 x 5a", tx_count - t0, last_tx); end
    tx_busy = 1'b1;
    t0 = tx_count;
    send_frame(8'h02, 8'h00, 8'h01, 8'h03);
    send_frame(8'h00, 8'h00, 8'h00, 8'h01);
    tick(3);
    tx_busy = 1'b0;
    tick(4);
    exp_duty[47:32] = 16'h0001;
    n_checks++; if (tx_count - t0 != 1 || last_tx !== 8'hEE || err_cnt !== 8'd4) begin n_fail++; $display("FAIL overwrite: got %0d x %h err %0d expected 1 x ee err 4", tx_count - t0, last_tx, err_cnt); end
    n_checks++; if (busy_wr != 0 || duty !== exp_duty) begin n_fail++; $display("FAIL busy_wr: got %0d busy writes duty %h expected 0 / %h", busy_wr, duty, exp_duty); end
  endtask

  task automatic test_err_saturate;
    for (int i = 0; i < 260; i++) send_frame(8'h00, 8'h00, 8'h10, 8'h11);
    tick(3);
    n_checks++; if (err_cnt !== 8'd255) begin n_fail++; $display("FAIL err_saturate: got %0d expected 255", err_cnt); end
  endtask

  task automatic test_reset_mid;
    t0 = tx_count;
    send_byte(8'hA5);
    send_byte(8'h03);
    send_byte(8'h12);
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(2);
    exp_duty = 64'd0;
    n_checks++; if (duty !== exp_duty || err_cnt !== 8'd0) begin n_fail++; $display("FAIL midrst_state: got %h/%0d expected 0/0", duty, err_cnt); end
    n_checks++; if (tx_count != t0 || tx_data !== 8'h00) begin n_fail++; $display("FAIL midrst_tx: got %0d writes data %h expected 0 / 00", tx_count - t0, tx_data); end
    send_frame(8'h03, 8'h00, 8'h07, 8'h04);
    tick(3);
    exp_duty[63:48] = 16'h0007;
    n_checks++; if (duty !== exp_duty || last_tx !== 8'h5A || err_cnt !== 8'd0) begin n_fail++; $display("FAIL midrst_recover: got %h/%h/%0d expected %h/5a/0", duty, last_tx, err_cnt, exp_duty); end
  endtask

  initial begin
    test_reset();
    test_ack_ch1();
    test_clamp();
    test_reject();
    test_sync_as_data();
    test_timeout();
    test_gap_boundary();
    test_back_to_back();
    test_err_saturate();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
